// File: rtl/tof_pkg.sv
// Shared types for the ToF peak collection slice.
// FSM encodings and result-word field offsets.
package tof_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    SETTLE_W = 2'd2,
    WAIT_HS  = 2'd3
  } state_e;

  localparam int WCNT_W   = 13;
  localparam int PEAK_LSB = 0;
  localparam int PEAK_W   = 4;
  localparam int FID_LSB  = 4;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy counter.
// Push is dropped when full, pop is dropped when empty.
module sync_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem[rd_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din_i;
  end

endmodule

// File: rtl/peak_collect.sv
// Windowed peak collection: gates the peak counter per window,
// handshakes its result and queues {frame_id, peak} downstream.
module peak_collect
  import tof_pkg::*;
#(
  parameter int WIN_LEN    = 4095,
  parameter int SETTLE     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int FID_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             hit_valid,
  output logic             peak_en,
  input  logic             peak_valid,
  input  logic [3:0]       peak_4bit,
  output logic             peak_ready,
  output logic             out_valid,
  output logic [FID_W+3:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf_err
);

  localparam int DW = FID_W + PEAK_W;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] win_q, win_d;
  logic [SW-1:0]     set_q, set_d;
  logic [FID_W-1:0]  fid_q, fid_d;
  logic              stop_q, stop_d;
  logic              ovf_q, ovf_d;

  logic              push;
  logic [DW-1:0]     din, dout;
  logic              f_full, f_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      win_q   <= '0;
      set_q   <= '0;
      fid_q   <= '0;
      stop_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      set_q   <= set_d;
      fid_q   <= fid_d;
      stop_q  <= stop_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    set_d      = set_q;
    fid_d      = fid_q;
    stop_d     = stop_q;
    ovf_d      = ovf_q;
    peak_en    = 1'b0;
    peak_ready = 1'b0;
    push       = 1'b0;
    if (state_q != IDLE && start) ovf_d  = 1'b1;
    if (state_q != IDLE && stop)  stop_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          win_d   = '0;
          stop_d  = 1'b0;
        end
      end
      ACCUM: begin
        peak_en = hit_valid;
        if (hit_valid) begin
          win_d = win_q + 1'b1;
          if (win_q + 1'b1 == WCNT_W'(WIN_LEN)) begin
            state_d = SETTLE_W;
            set_d   = '0;
          end
        end
      end
      SETTLE_W: begin
        if (set_q == SW'(SETTLE - 1)) begin
          state_d = WAIT_HS;
          set_d   = '0;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      WAIT_HS: begin
        peak_ready = !f_full;
        if (peak_valid && !f_full) begin
          push    = 1'b1;
          fid_d   = fid_q + 1'b1;
          win_d   = '0;
          // a stop in the handshake cycle still ends the run here
          state_d = (stop_q || stop) ? IDLE : ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din = '0;
    din[FID_LSB +: FID_W]   = fid_q;
    din[PEAK_LSB +: PEAK_W] = peak_4bit;
  end

  sync_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (out_valid && out_ready),
    .dout_o  (dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign out_valid = !f_empty;
  assign out_data  = f_empty ? '0 : dout;
  assign busy      = (state_q != IDLE);
  assign ovf_err   = ovf_q;

endmodule

// File: doc/peak_collect.md
PEAK_COLLECT -- requirements
Module: peak_collect

Interface
REQ-001 Parameter WIN_LEN, default 4095: enabled sample cycles per integration window; valid range 1..8191.
REQ-002 Parameter SETTLE, default 5: cycles after the last enabled sample before the peak result is trusted; matches the 4-stage peak-search pipeline plus 1.
REQ-003 Parameter FIFO_DEPTH, default 4: depth of the result FIFO; power of 2.
REQ-004 Parameter FID_W, default 8: frame-id width.
REQ-005 Reset is rstn, asynchronous, active-low; the clock is clk.
REQ-006 Port clk, input, 1: clock.
REQ-007 Port rstn, input, 1: asynchronous active-low reset.
REQ-008 Port start, input, 1: single-cycle pulse that starts continuous windowing.
REQ-009 Port stop, input, 1: single-cycle pulse that ends windowing after the current window.
REQ-010 Port hit_valid, input, 1: a TDC sample is present this cycle.
REQ-011 Port peak_en, output, 1: count enable to the peak counter.
REQ-012 Port peak_valid, input, 1: peak result valid, from the peak counter.
REQ-013 Port peak_4bit, input, 4: peak bin value.
REQ-014 Port peak_ready, output, 1: handshake ready to the peak counter; also clears its histogram.
REQ-015 Port out_valid, output, 1: downstream result valid.
REQ-016 Port out_data, output, FID_W+4: result word {frame_id, peak_4bit}.
REQ-017 Port out_ready, input, 1: downstream ready.
REQ-018 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-019 Port ovf_err, output, 1: sticky flag; set when start arrives while busy.

Function
REQ-020 The FSM SHALL have the states IDLE, ACCUM, SETTLE_W and WAIT_HS.
REQ-021 IDLE: on start, go to ACCUM, clear the window counter and clear stop_pend.
REQ-022 ACCUM: peak_en = hit_valid (combinational).
REQ-023 ACCUM: the window counter increments on each cycle where hit_valid is high.
REQ-024 ACCUM: when the increment brings the counter to WIN_LEN, go to SETTLE_W on the next cycle.
REQ-025 peak_en SHALL be 0 in every state other than ACCUM.
REQ-026 SETTLE_W: count exactly SETTLE cycles, then go to WAIT_HS.
REQ-027 WAIT_HS: peak_ready = !fifo_full.
REQ-028 WAIT_HS: a handshake is peak_valid && peak_ready.
REQ-029 On a handshake, push {frame_id, peak_4bit} into the FIFO and increment frame_id, wrapping from 2^FID_W-1 to 0.
REQ-030 After a handshake, go to IDLE if stop_pend is set; otherwise go to ACCUM with the window counter cleared.
REQ-031 peak_ready SHALL be 0 in every state other than WAIT_HS, and SHALL be high for exactly 1 cycle per window.
REQ-032 A stop pulse in any non-IDLE state sets stop_pend; the current window always completes and its result is always pushed.
REQ-033 stop in IDLE is ignored.
REQ-034 start while busy is ignored and sets ovf_err; ovf_err clears only on reset.
REQ-035 Simultaneous start and stop in IDLE: start wins, stop is ignored.
REQ-036 FIFO full in WAIT_HS: hold with peak_ready=0. No window starts and no sample is counted until an entry drains.
REQ-037 FIFO output: out_valid = !fifo_empty; out_data = the head entry; pop on out_valid && out_ready.
REQ-038 Push and pop in the same cycle are both performed and the occupancy is unchanged; since push requires !full, there is no overwrite.
REQ-039 out_data SHALL be stable while out_valid && !out_ready.
REQ-040 Latency: the last counted sample at cycle t gives peak_ready high no earlier than t+1+SETTLE; a pushed entry is visible on out_valid the cycle after the push.
REQ-041 Width rule: the window counter is 13 bits, so the peak counter's 13-bit bins never wrap.

Reset
REQ-042 rstn low SHALL asynchronously force: state=IDLE, window/settle counters=0, frame_id=0, stop_pend=0, ovf_err=0, FIFO empty, all outputs 0.
REQ-043 Reset mid-window SHALL abandon the window; the in-flight result is never pushed.

Structure
REQ-044 FSM state encodings and the out_data field offsets SHALL live in the shared package tof_pkg.
REQ-045 The FIFO SHALL be a separate sub-module named sync_fifo, parameterised by width and depth, with full/empty outputs.

Verification
REQ-046 Basic window: WIN_LEN=8, start, hit_valid high for 8 cycles, peak_valid=1 with peak_4bit=4'hA -> peak_en high for exactly 8 cycles; peak_ready pulses once 6 cycles after the last sample; out_data=12'h00A.
REQ-047 Gapped hits: WIN_LEN=8, hit_valid alternating 1/0 -> ACCUM lasts 16 cycles; peak_en toggles with hit_valid.
REQ-048 Backpressure: FIFO_DEPTH=4, out_ready=0, 5 windows -> 4 entries with frame_id 0..3; the FSM holds in WAIT_HS with peak_ready=0; on out_ready=1, the 5th push occurs and the entry order is preserved.
REQ-049 Stop mid-window: stop at sample 3 of 8 -> the window completes, 1 result is pushed, the FSM returns to IDLE and busy drops.
REQ-050 start while busy -> ovf_err=1, the frame sequence is unaffected; a wrap test of 257 windows gives frame_id 0xFF followed by 0x00.
REQ-051 Reset asserted while in SETTLE_W -> all outputs are 0 immediately and no FIFO entry is ever produced for that window.
